if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, 32'h0000_0013, bubble encoding driven on if_inst_o when no valid instruction is held.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ctrl_signal_i  input  CTRL_Wire_Bus  pipeline control: CTRL_STATE_Default, CTRL_STATE_Stalled; any other value = flush.
REQ-006 redirect_valid_i  input  1  branch/jump/trap redirect request.
REQ-007 redirect_pc_i  input  64  redirect target.
REQ-008 imem_req_valid_o  output  1  instruction-memory request valid.
REQ-009 imem_req_addr_o  output  64  request address.
REQ-010 imem_req_ready_i  input  1  memory accepts request.
REQ-011 imem_resp_valid_i  input  1  response valid, one cycle per accepted request, in order.
REQ-012 imem_resp_data_i  input  32  fetched instruction word.
REQ-013 pc_o  output  64  PC of instruction on if_inst_o, feeding the decode pipeline register.
REQ-014 if_inst_o  output  32  fetched instruction, or NOP_INST when if_valid_o=0.
REQ-015 if_valid_o  output  1  output slot holds a valid instruction.

Function
REQ-016 State: fetch_pc (64b), inflight_pc (64b), drop flag, output slot (pc_o/if_inst_o/if_valid_o registers), FSM {IDLE, REQ, WAIT}.
REQ-017 IDLE: one cycle after reset, no request; next state REQ.
REQ-018 REQ: imem_req_valid_o=1, imem_req_addr_o=fetch_pc; on imem_req_ready_i=1: inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^64), next WAIT.
REQ-019 Once imem_req_valid_o is asserted, valid and address hold stable until handshake, including across stall, flush and redirect.
REQ-020 REQ is entered only when the output slot is empty, or is being consumed this cycle (if_valid_o=1 and ctrl_signal_i != Stalled); otherwise FSM waits in WAIT/IDLE-equivalent hold with imem_req_valid_o=0. At most one request outstanding.
REQ-021 WAIT: on imem_resp_valid_i=1 with drop=0: slot<= {inflight_pc, imem_resp_data_i, valid=1}, next REQ if slot free next cycle, else hold. With drop=1: discard response, drop<=0, next REQ.
REQ-022 Slot consume: cycle with if_valid_o=1 and ctrl_signal_i=Default -> next cycle if_valid_o=0, if_inst_o=NOP_INST unless refilled same edge.
REQ-023 Stall: ctrl_signal_i=Stalled -> slot contents unchanged; in-flight request continues; response arriving into a full slot is impossible by REQ-020.
REQ-024 Flush (non-Default, non-Stalled): slot cleared (if_valid_o=0, if_inst_o=NOP_INST, pc_o unchanged); fetch continues.
REQ-025 Redirect (redirect_valid_i=1): fetch_pc<={redirect_pc_i[63:2],2'b00}; slot cleared; any request accepted-but-unanswered, or currently presented in REQ, or accepted this cycle, marked drop=1.
REQ-026 Redirect priority over flush, stall and same-cycle response; a response coinciding with redirect is discarded.
REQ-027 Response while in IDLE or REQ (no outstanding request) is ignored.
REQ-028 Latency: request handshake at cycle N, response at N+k -> if_valid_o=1 at N+k+1.

Reset
REQ-029 On rst=1 at clock edge: FSM<=IDLE, fetch_pc<=RESET_PC, inflight_pc<=0, drop<=0, imem_req_valid_o=0, imem_req_addr_o=RESET_PC, pc_o=0, if_inst_o=NOP_INST, if_valid_o=0.
REQ-030 Reset mid-operation abandons any outstanding request; late responses handled per REQ-027.

Verification
REQ-031 Reset release, ready=1, 1-cycle memory -> requests to 0x80000000, 0x80000004, 0x80000008 in order; pc_o/if_inst_o follow with if_valid_o=1.
REQ-032 ready=0 for 3 cycles with Stalled toggling -> imem_req_valid_o and address 0x80000000 stable until handshake.
REQ-033 Slot full, Stalled for 4 cycles -> if_inst_o/pc_o constant, no new request issued; Default -> consumed, next request issued same cycle.
REQ-034 Redirect to 0x80001003 while in WAIT -> pending response discarded, next request address 0x80001000, slot shows NOP_INST/if_valid_o=0 until its response.
REQ-035 Redirect same cycle as resp_valid -> response dropped; flush with slot full -> if_valid_o=0, if_inst_o=32'h00000013.
REQ-036 rst asserted in WAIT, response arrives next cycle -> ignored; outputs at reset values; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry output slot feeding decode.
// Latency: request handshake at N, response at N+k -> if_valid_o at N+k+1.
// Backpressure: a new request is issued only when the slot is empty or leaving; requests hold until ready.
//
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   ctrl_signal_i                      Default / Stalled / anything else = flush
//   redirect_valid_i, redirect_pc_i    branch/jump/trap redirect
//   imem_req_valid_o/addr_o/ready_i    request channel to instruction memory
//   imem_resp_valid_i/data_i           in-order response, one per accepted request
//   pc_o, if_inst_o, if_valid_o        output slot toward the decode pipeline register

package if_fetch_pkg;
  typedef enum logic [1:0] {
    CTRL_STATE_Default = 2'b00,
    CTRL_STATE_Stalled = 2'b01,
    CTRL_STATE_Flush   = 2'b10
  } CTRL_Wire_Bus;
endpackage

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  CTRL_Wire_Bus ctrl_signal_i,
  input  logic         redirect_valid_i,
  input  logic [63:0]  redirect_pc_i,
  output logic         imem_req_valid_o,
  output logic [63:0]  imem_req_addr_o,
  input  logic         imem_req_ready_i,
  input  logic         imem_resp_valid_i,
  input  logic [31:0]  imem_resp_data_i,
  output logic [63:0]  pc_o,
  output logic [31:0]  if_inst_o,
  output logic         if_valid_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  // Address currently presented; decoupled from fetch_pc so a redirect
  // can update the fetch target while an unaccepted request stays stable.
  logic [63:0] req_addr_q, req_addr_d;
  logic [63:0] inflight_pc_q, inflight_pc_d;
  logic        drop_q, drop_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        vld_q, vld_d;

  logic        stalled;
  logic        handshake;
  logic        resp_hit;
  logic        resp_fill;
  logic        slot_frees;
  logic [63:0] redirect_target;
  logic        unused_pc_lsbs;

  assign unused_pc_lsbs  = ^redirect_pc_i[1:0];
  assign redirect_target = {redirect_pc_i[63:2], 2'b00};

  assign stalled    = (ctrl_signal_i == CTRL_STATE_Stalled);
  assign handshake  = (state_q == REQ) && imem_req_ready_i;
  // Responses count only when a request is outstanding.
  assign resp_hit   = (state_q == WAIT) && imem_resp_valid_i;
  assign resp_fill  = resp_hit && !drop_q && !redirect_valid_i;
  // Slot is empty next cycle: already empty, consumed/flushed, or cleared by redirect.
  assign slot_frees = !vld_q || !stalled || redirect_valid_i;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (slot_frees) state_d = REQ;
      end
      REQ: begin
        if (imem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (resp_hit) begin
          if (resp_fill) state_d = IDLE;  // slot just filled, hold until it leaves
          else if (slot_frees) state_d = REQ;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch address, drop tracking and output slot.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_addr_d    = req_addr_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = drop_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    vld_d         = vld_q;

    if (redirect_valid_i) begin
      fetch_pc_d = redirect_target;
    end else if (handshake && !drop_q) begin
      fetch_pc_d = req_addr_q + 64'd4;
    end
    // A request already redirected away keeps fetch_pc at the redirect target.

    if (handshake) inflight_pc_d = req_addr_q;

    // Presented address only moves when nothing is presented or it was just accepted.
    if (!imem_req_valid_o || handshake) req_addr_d = fetch_pc_d;

    if (resp_hit) begin
      drop_d = 1'b0;  // the single outstanding response has been seen
    end else if (redirect_valid_i && (state_q == REQ || state_q == WAIT)) begin
      drop_d = 1'b1;
    end

    if (redirect_valid_i) begin
      vld_d  = 1'b0;
      inst_d = NOP_INST;
    end else if (resp_fill) begin
      pc_d   = inflight_pc_q;
      inst_d = imem_resp_data_i;
      vld_d  = 1'b1;
    end else if (!stalled) begin
      // Default consumes, anything else flushes; both empty the slot.
      vld_d  = 1'b0;
      inst_d = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      req_addr_q    <= RESET_PC;
      inflight_pc_q <= 64'd0;
      drop_q        <= 1'b0;
      pc_q          <= 64'd0;
      inst_q        <= NOP_INST;
      vld_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_addr_q    <= req_addr_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      vld_q         <= vld_d;
    end
  end

  assign imem_req_valid_o = (state_q == REQ);
  assign imem_req_addr_o  = req_addr_q;
  assign pc_o             = pc_q;
  assign if_inst_o        = inst_q;
  assign if_valid_o       = vld_q;

endmodule
